// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser with optional parity
module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        serial_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    // Cycles per line bit; every bit (start, data, parity, stop) lasts exactly this long.
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int BIT_CNT_W        = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam int PTR_W            = $clog2(FIFO_DEPTH);
    localparam int COUNT_W          = PTR_W + 1;

    localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [COUNT_W-1:0]   DEPTH      = COUNT_W'(FIFO_DEPTH);
    localparam logic                 ODD_SENSE  = (PARITY_ODD != 0);
    localparam logic                 HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic [7:0]         head;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Serialiser state
    state_t               state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;
    logic                 parity_bit;
    logic                 bit_last;

    assign fifo_empty    = (count == '0);
    assign head          = mem[rd_ptr];
    assign fifo_count    = count;

    // Ready is held low during reset so nothing is written while the FIFO is being flushed.
    assign data_in_ready = (count < DEPTH) && !rst;
    assign push          = data_in_valid && data_in_ready;

    assign bit_last      = (bit_cnt == BIT_LAST);

    // A byte leaves the FIFO either from idle or on the final cycle of a stop bit,
    // which is what gives back-to-back frames with no idle gap.
    assign pop           = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_last));

    assign busy          = (state != IDLE) || !fifo_empty;

    // FIFO data array: written on push only; no reset needed since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Frame serialiser: start, 8 data bits LSB first, optional parity, stop; line driven from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            serial_out <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                    if (pop) begin
                        shreg      <= head;
                        parity_bit <= (^head) ^ ODD_SENSE;
                        state      <= START;
                        serial_out <= 1'b0;
                    end
                end

                START: begin
                    if (bit_last) begin
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        serial_out <= shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                        state      <= DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PARITY) begin
                                serial_out <= parity_bit;
                                state      <= PARITY;
                            end else begin
                                serial_out <= 1'b1;
                                state      <= STOP;
                            end
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            serial_out <= shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_last) begin
                        bit_cnt    <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            shreg      <= head;
                            parity_bit <= (^head) ^ ODD_SENSE;
                            serial_out <= 1'b0;
                            state      <= START;
                        end else begin
                            serial_out <= 1'b1;
                            state      <= IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    bit_cnt    <= '0;
                    serial_out <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
